// File: rtl/adc_acq_sequencer.sv
// ADC acquisition sequencer: paces conversions at a programmable period, runs the
// start/drdy handshake, forwards captured codes and tracks burst, drop and timeout status.
module adc_acq_sequencer #(
    parameter int DATA_W     = 16,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 255,
    parameter int MIN_PERIOD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [CNT_W-1:0]  period,
    input  logic [CNT_W-1:0]  burst_len,
    output logic              adc_start,
    input  logic              adc_drdy,
    input  logic [DATA_W-1:0] adc_code,
    input  logic              fifo_full,
    output logic              proc_valid,
    output logic [DATA_W-1:0] proc_data,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        CONVERT = 2'd2,
        WAIT    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] shadow_period;
    logic [CNT_W-1:0] shadow_burst;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] timeout_cnt;
    logic [CNT_W-1:0] burst_cnt;
    logic             enable_q;

    logic period_expired;
    logic burst_complete;
    logic tmo_expired;
    logic start_acq;
    logic err_clear;
    logic accept;
    logic drop;
    logic tmo_hit;
    logic burst_done;

    // The period counter is loaded during START, so it reads 1 in the last cycle
    // of the period; treating 1 as expired keeps starts exactly shadow_period apart.
    assign period_expired = (period_cnt <= ONE);
    assign burst_complete = (shadow_burst != '0) && (burst_cnt == shadow_burst);
    // timeout_cnt lags adc_start by one clock: this aborts on the edge that lands
    // TIMEOUT clocks after the adc_start cycle.
    assign tmo_expired    = (timeout_cnt == TMO_LAST);

    assign adc_start = (state == START);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            enable_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            enable_q <= enable;
        end
    end

    always_comb begin
        state_nxt  = state;
        start_acq  = 1'b0;
        err_clear  = 1'b0;
        accept     = 1'b0;
        drop       = 1'b0;
        tmo_hit    = 1'b0;
        burst_done = 1'b0;
        case (state)
            IDLE: begin
                // A fresh enable edge only clears a sticky error; the start follows next cycle.
                if (enable && !enable_q && timeout_err) begin
                    err_clear = 1'b1;
                end else if (enable && !timeout_err) begin
                    start_acq = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = CONVERT;
            end
            CONVERT: begin
                if (adc_drdy) begin
                    accept    = !fifo_full;
                    drop      = fifo_full;
                    state_nxt = WAIT;
                end else if (tmo_expired) begin
                    tmo_hit   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (period_expired) begin
                    if (burst_complete) begin
                        burst_done = 1'b1;
                        state_nxt  = IDLE;
                    end else if (!enable) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = START;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_period <= '0;
            shadow_burst  <= '0;
        end else if (start_acq) begin
            shadow_period <= (period < MIN_P) ? MIN_P : period;
            shadow_burst  <= burst_len;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt  <= '0;
            timeout_cnt <= '0;
            burst_cnt   <= '0;
        end else begin
            if (state == START) begin
                period_cnt  <= shadow_period - ONE;
                timeout_cnt <= '0;
                burst_cnt   <= burst_cnt + ONE;
            end else begin
                if (period_cnt != '0) begin
                    period_cnt <= period_cnt - ONE;
                end
                if (state == CONVERT) begin
                    timeout_cnt <= timeout_cnt + ONE;
                end
                if (start_acq) begin
                    burst_cnt <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proc_valid <= 1'b0;
            proc_data  <= '0;
            done       <= 1'b0;
        end else begin
            proc_valid <= accept;
            done       <= burst_done;
            if (accept) begin
                proc_data <= adc_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            drop_cnt   <= '0;
        end else if (start_acq) begin
            sample_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            if (accept) begin
                sample_cnt <= sample_cnt + ONE;
            end
            if (drop && (drop_cnt != CNT_MAX)) begin
                drop_cnt <= drop_cnt + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (tmo_hit) begin
            timeout_err <= 1'b1;
        end else if (err_clear) begin
            timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Self-checking bench for adc_acq_sequencer: an ADC model answers adc_start, a
// scoreboard queue holds the codes that must come out on proc_valid/proc_data.
module tb_adc_acq_sequencer;

    localparam int DATA_W     = 16;
    localparam int CNT_W      = 16;
    localparam int TIMEOUT    = 255;
    localparam int MIN_PERIOD = 4;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  burst_len;
    logic              adc_start;
    logic              adc_drdy;
    logic [DATA_W-1:0] adc_code;
    logic              fifo_full;
    logic              proc_valid;
    logic [DATA_W-1:0] proc_data;
    logic              busy;
    logic              done;
    logic              timeout_err;
    logic [CNT_W-1:0]  sample_cnt;
    logic [CNT_W-1:0]  drop_cnt;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    logic [DATA_W-1:0] code_tab[$];
    bit                full_tab[$];
    logic [DATA_W-1:0] sb_q[$];
    int                start_q[$];
    int                drdy_delay     = 3;
    bit                adc_respond    = 1'b0;
    bit                expect_deliver = 1'b1;
    int                conv_idx       = 0;
    int                valid_cnt      = 0;
    int                done_cnt       = 0;

    adc_acq_sequencer #(
        .DATA_W     (DATA_W),
        .CNT_W      (CNT_W),
        .TIMEOUT    (TIMEOUT),
        .MIN_PERIOD (MIN_PERIOD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .period      (period),
        .burst_len   (burst_len),
        .adc_start   (adc_start),
        .adc_drdy    (adc_drdy),
        .adc_code    (adc_code),
        .fifo_full   (fifo_full),
        .proc_valid  (proc_valid),
        .proc_data   (proc_data),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .sample_cnt  (sample_cnt),
        .drop_cnt    (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Expected start-to-start spacing: clamped period, stretched by a late drdy.
    function automatic int exp_spacing(input int p, input int dly);
        int pc;
        pc = (p < MIN_PERIOD) ? MIN_PERIOD : p;
        return (dly + 2 > pc) ? dly + 2 : pc;
    endfunction

    // ADC model: answers each adc_start with drdy dly clocks later.
    initial begin
        logic [DATA_W-1:0] cur_code;
        bit                cur_full;
        adc_drdy  = 1'b0;
        adc_code  = '0;
        fifo_full = 1'b0;
        forever begin
            @(negedge clk);
            if (adc_start === 1'b1 && adc_respond) begin
                cur_code = (code_tab.size() > 0) ? code_tab[conv_idx % code_tab.size()] : 16'h5A5A;
                cur_full = (full_tab.size() > 0) ? full_tab[conv_idx % full_tab.size()] : 1'b0;
                conv_idx++;
                repeat (drdy_delay) @(negedge clk);
                adc_drdy  = 1'b1;
                adc_code  = cur_code;
                fifo_full = cur_full;
                if (expect_deliver && !cur_full) sb_q.push_back(cur_code);
                @(negedge clk);
                adc_drdy  = 1'b0;
                fifo_full = 1'b0;
                adc_code  = 16'($urandom);
            end
        end
    end

    // Output monitor: records starts/done and pops the scoreboard on proc_valid.
    initial begin
        logic [DATA_W-1:0] exp_code;
        forever begin
            @(negedge clk);
            if (adc_start === 1'b1) start_q.push_back(cycle);
            if (done === 1'b1) done_cnt++;
            if (proc_valid === 1'b1) begin
                valid_cnt++;
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_valid", 32'(proc_valid), 32'd0);
                end else begin
                    exp_code = sb_q.pop_front();
                    checkOutput("proc_data", 32'(proc_data), 32'(exp_code));
                end
            end
        end
    end

    task automatic applyStimulus(input int p, input int b, input int dly);
        sb_q.delete();
        start_q.delete();
        valid_cnt      = 0;
        done_cnt       = 0;
        conv_idx       = 0;
        drdy_delay     = dly;
        adc_respond    = 1'b1;
        expect_deliver = 1'b1;
        period         = 16'(p);
        burst_len      = 16'(b);
        @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        checkOutput("done_seen", 32'(done), 32'd1);
        enable = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        checkOutput("wait_idle", 32'(busy), 32'd0);
    endtask

    task automatic check_run(input string tag, input int n_starts, input int spacing,
                             input int n_valid, input int n_drop, input int n_done);
        repeat (3) @(negedge clk);
        #1;
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_starts"}, 32'(start_q.size()), 32'(n_starts));
        for (int i = 1; i < start_q.size(); i++)
            checkOutput({tag, "_spacing"}, 32'(start_q[i] - start_q[i-1]), 32'(spacing));
        checkOutput({tag, "_sample_cnt"}, 32'(sample_cnt), 32'(n_valid));
        checkOutput({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(n_drop));
        checkOutput({tag, "_valids"}, 32'(valid_cnt), 32'(n_valid));
        checkOutput({tag, "_dones"}, 32'(done_cnt), 32'(n_done));
        checkOutput({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen;
        int t_start;
        int v0;

        rst_n     = 1'b0;
        enable    = 1'b0;
        period    = '0;
        burst_len = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_adc_start", 32'(adc_start), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_proc_valid", 32'(proc_valid), 32'd0);
        checkOutput("rst_proc_data", 32'(proc_data), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("rst_counts", 32'({sample_cnt, drop_cnt}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] test 1: burst of 4, period 10");
        code_tab = '{16'h1234, 16'h8000, 16'hFFFF, 16'h0000};
        full_tab = '{1'b0, 1'b0, 1'b0, 1'b0};
        applyStimulus(10, 4, 3);
        wait_done(200);
        check_run("t1", 4, exp_spacing(10, 3), 4, 0, 1);

        $display("[TB] test 2: fifo_full on 2nd and 3rd drdy");
        code_tab = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
        full_tab = '{1'b0, 1'b1, 1'b1, 1'b0};
        applyStimulus(10, 4, 3);
        wait_done(200);
        check_run("t2", 4, exp_spacing(10, 3), 2, 2, 1);

        $display("[TB] test 3: period clamp and stretch");
        code_tab = '{16'h0AAA, 16'h0BBB, 16'h0CCC};
        full_tab.delete();
        applyStimulus(2, 3, 2);
        wait_done(100);
        check_run("t3a", 3, exp_spacing(2, 2), 3, 0, 1);
        // drdy on the 7th clock counting the start clock
        applyStimulus(5, 3, 6);
        wait_done(100);
        check_run("t3b", 3, exp_spacing(5, 6), 3, 0, 1);

        $display("[TB] test 4: continuous, enable dropped after 3rd start");
        code_tab = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        applyStimulus(10, 0, 3);
        seen = 0;
        for (int i = 0; i < 100 && seen < 3; i++) begin
            @(negedge clk);
            if (adc_start === 1'b1) seen++;
        end
        @(negedge clk);
        enable = 1'b0;
        wait_idle(100);
        check_run("t4", 3, exp_spacing(10, 3), 3, 0, 0);

        $display("[TB] test 5: conversion timeout");
        code_tab = '{16'h7777};
        applyStimulus(10, 0, 3);
        adc_respond = 1'b0;
        t_start = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (adc_start === 1'b1) begin
                t_start = i;
                break;
            end
        end
        checkOutput("t5_start_seen", 32'(adc_start), 32'd1);
        repeat (TIMEOUT - 1) @(negedge clk);
        checkOutput("t5_err_before", 32'(timeout_err), 32'd0);
        checkOutput("t5_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("t5_err_set", 32'(timeout_err), 32'd1);
        checkOutput("t5_idle", 32'(busy), 32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (adc_start === 1'b1) seen++;
        end
        checkOutput("t5_no_restart", 32'(seen), 32'd0);
        checkOutput("t5_err_sticky", 32'(timeout_err), 32'd1);
        adc_respond = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        checkOutput("t5_err_cleared", 32'(timeout_err), 32'd0);
        @(negedge clk);
        checkOutput("t5_restart", 32'(adc_start), 32'd1);
        @(negedge clk);
        enable = 1'b0;
        wait_idle(100);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("t5_sample_cnt", 32'(sample_cnt), 32'd1);
        checkOutput("t5_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] test 6: reset during CONVERT and during adc_start");
        code_tab = '{16'hC001, 16'hC002};
        applyStimulus(10, 0, 2);
        seen = 0;
        for (int i = 0; i < 100 && seen < 2; i++) begin
            @(negedge clk);
            if (adc_start === 1'b1) seen++;
        end
        @(negedge clk);
        checkOutput("t6_pre_sample_cnt", 32'(sample_cnt), 32'd1);
        checkOutput("t6_pre_busy", 32'(busy), 32'd1);
        expect_deliver = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t6_conv_busy", 32'(busy), 32'd0);
        checkOutput("t6_conv_adc_start", 32'(adc_start), 32'd0);
        checkOutput("t6_conv_proc_valid", 32'(proc_valid), 32'd0);
        checkOutput("t6_conv_counts", 32'({sample_cnt, drop_cnt}), 32'd0);
        enable = 1'b0;
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        v0 = valid_cnt;
        checkOutput("t6_late_drdy_valids", 32'(v0), 32'd1);
        checkOutput("t6_late_drdy_busy", 32'(busy), 32'd0);
        @(negedge clk);
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (adc_start === 1'b1) break;
        end
        checkOutput("t6_start_seen", 32'(adc_start), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t6_start_adc_start", 32'(adc_start), 32'd0);
        checkOutput("t6_start_busy", 32'(busy), 32'd0);
        checkOutput("t6_start_counts", 32'({sample_cnt, drop_cnt}), 32'd0);
        enable = 1'b0;
        #1 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        checkOutput("t6_final_busy", 32'(busy), 32'd0);
        checkOutput("t6_final_valids", 32'(valid_cnt), 32'(v0));
        checkOutput("t6_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
